// File: rtl/address_map_pkg.sv
// Shared types and constants for the programmable SNES-to-ROM address map:
// region record layout, register offsets, flag bit positions and reset defaults.
package address_map_pkg;

  localparam logic [3:0] REG_BANK_LO = 4'd0;
  localparam logic [3:0] REG_BANK_HI = 4'd1;
  localparam logic [3:0] REG_PAGE_LO = 4'd2;
  localparam logic [3:0] REG_PAGE_HI = 4'd3;
  localparam logic [3:0] REG_BASE0   = 4'd4;
  localparam logic [3:0] REG_BASE1   = 4'd5;
  localparam logic [3:0] REG_BASE2   = 4'd6;
  localparam logic [3:0] REG_MASK0   = 4'd7;
  localparam logic [3:0] REG_MASK1   = 4'd8;
  localparam logic [3:0] REG_MASK2   = 4'd9;
  localparam logic [3:0] REG_FLAGS   = 4'd10;

  localparam int F_ENABLE       = 5;
  localparam int F_MIRROR80     = 4;
  localparam int F_LOROM        = 3;
  localparam int F_WRITABLE     = 2;
  localparam int F_SAVERAM      = 1;
  localparam int F_NEEDS_ROMSEL = 0;

  typedef struct packed {
    logic [7:0]  bank_lo;
    logic [7:0]  bank_hi;
    logic [7:0]  page_lo;
    logic [7:0]  page_hi;
    logic [23:0] base;
    logic [23:0] mask;
    logic [5:0]  flags;
  } region_t;

  // Power-on map: LoROM program space, HiROM-style linear space and two SaveRAM windows.
  function automatic region_t region_default(input int idx, input logic [23:0] saveram_mask);
    region_t r;
    r = '0;
    case (idx)
      0: begin
        r.bank_lo = 8'h00; r.bank_hi = 8'h3F; r.page_lo = 8'h80; r.page_hi = 8'hFF;
        r.base = 24'h000000; r.mask = 24'hFFFFFF; r.flags = 6'b111001;
      end
      1: begin
        r.bank_lo = 8'h40; r.bank_hi = 8'h5F; r.page_lo = 8'h00; r.page_hi = 8'hFF;
        r.base = 24'h000000; r.mask = 24'hFFFFFF; r.flags = 6'b110001;
      end
      2: begin
        r.bank_lo = 8'h00; r.bank_hi = 8'h3F; r.page_lo = 8'h60; r.page_hi = 8'h7F;
        r.base = 24'hE00000; r.mask = 24'h001FFF; r.flags = 6'b110110;
      end
      3: begin
        r.bank_lo = 8'h60; r.bank_hi = 8'h7D; r.page_lo = 8'h00; r.page_hi = 8'hFF;
        r.base = 24'hE00000; r.mask = saveram_mask; r.flags = 6'b110111;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/address_map_region.sv
// One map window: shadow/active register sets, match logic, and this window's
// stage-1 snapshot so an in-flight lookup finishes with the map it started on.
module address_map_region
  import address_map_pkg::*;
#(
  parameter int          IDX          = 0,
  parameter logic [23:0] SAVERAM_MASK = 24'h00FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        we,
  input  logic [3:0]  reg_sel,
  input  logic [7:0]  data,
  input  logic        commit,
  input  logic        lookup,
  input  logic [23:0] snes_addr,
  input  logic        snes_romsel,
  output logic        hit,
  output logic [23:0] masked,
  output logic [23:0] base,
  output logic        saveram,
  output logic        writable
);

  localparam region_t DEF = region_default(IDX, SAVERAM_MASK);

  region_t     shadow;
  region_t     active;
  logic [7:0]  bank;
  logic [7:0]  page;
  logic        match;
  logic [23:0] offset;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow <= DEF;
    end else if (we) begin
      case (reg_sel)
        REG_BANK_LO: shadow.bank_lo      <= data;
        REG_BANK_HI: shadow.bank_hi      <= data;
        REG_PAGE_LO: shadow.page_lo      <= data;
        REG_PAGE_HI: shadow.page_hi      <= data;
        REG_BASE0:   shadow.base[7:0]    <= data;
        REG_BASE1:   shadow.base[15:8]   <= data;
        REG_BASE2:   shadow.base[23:16]  <= data;
        REG_MASK0:   shadow.mask[7:0]    <= data;
        REG_MASK1:   shadow.mask[15:8]   <= data;
        REG_MASK2:   shadow.mask[23:16]  <= data;
        REG_FLAGS:   shadow.flags        <= data[5:0];
        default: ;
      endcase
    end
  end

  // Shadow is sampled before this edge's write lands, so a coincident write waits for the next commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active <= DEF;
    end else if (commit) begin
      active <= shadow;
    end
  end

  always_comb begin
    bank   = {active.flags[F_MIRROR80] ? 1'b0 : snes_addr[23], snes_addr[22:16]};
    page   = snes_addr[15:8];
    match  = active.flags[F_ENABLE] &&
             (bank >= active.bank_lo) && (bank <= active.bank_hi) &&
             (page >= active.page_lo) && (page <= active.page_hi) &&
             (!active.flags[F_NEEDS_ROMSEL] || !snes_romsel);
    // LoROM offset uses the mirrored bank so 80-BF folds onto 00-3F.
    offset = active.flags[F_LOROM] ? {1'b0, bank, snes_addr[14:0]} : snes_addr;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit      <= 1'b0;
      masked   <= '0;
      base     <= '0;
      saveram  <= 1'b0;
      writable <= 1'b0;
    end else if (lookup) begin
      hit      <= match;
      masked   <= offset & active.mask;
      base     <= active.base;
      saveram  <= active.flags[F_SAVERAM];
      writable <= active.flags[F_WRITABLE];
    end
  end

endmodule

// File: rtl/address_map.sv
// Programmable SNES address translator: config decode, NUM_REGIONS windows,
// and a two-stage lookup pipeline (match snapshot, then priority select + base add).
module address_map
  import address_map_pkg::*;
#(
  parameter int          NUM_REGIONS        = 4,
  parameter logic [23:0] RESET_SAVERAM_MASK = 24'h00FFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  input  logic        addr_valid,
  input  logic [23:0] SNES_ADDR,
  input  logic        SNES_ROMSEL,
  output logic        out_valid,
  output logic [23:0] ROM_ADDR,
  output logic        ROM_HIT,
  output logic        IS_SAVERAM,
  output logic        IS_ROM,
  output logic        IS_WRITABLE,
  output logic [2:0]  region_idx
);

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] saveram;
  logic [NUM_REGIONS-1:0] writable;
  logic [23:0]            masked [NUM_REGIONS];
  logic [23:0]            base   [NUM_REGIONS];
  logic                   reg_ok;
  logic                   s1_valid;
  logic                   s1_romsel;

  logic                   any_hit;
  logic [2:0]             win_idx;
  logic [23:0]            win_base;
  logic [23:0]            win_off;
  logic                   win_sav;
  logic                   win_wr;

  assign reg_ok = (cfg_addr[3:0] <= REG_FLAGS);

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    address_map_region #(
      .IDX          (g),
      .SAVERAM_MASK (RESET_SAVERAM_MASK)
    ) u_region (
      .CLK         (CLK),
      .RST         (RST),
      .we          (cfg_we && reg_ok && (cfg_addr[6:4] == 3'(g))),
      .reg_sel     (cfg_addr[3:0]),
      .data        (cfg_data),
      .commit      (cfg_commit),
      .lookup      (addr_valid),
      .snes_addr   (SNES_ADDR),
      .snes_romsel (SNES_ROMSEL),
      .hit         (hit[g]),
      .masked      (masked[g]),
      .base        (base[g]),
      .saveram     (saveram[g]),
      .writable    (writable[g])
    );
  end

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    any_hit  = 1'b0;
    win_idx  = '0;
    win_base = '0;
    win_off  = '0;
    win_sav  = 1'b0;
    win_wr   = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        win_idx  = 3'(i);
        win_base = base[i];
        win_off  = masked[i];
        win_sav  = saveram[i];
        win_wr   = writable[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid    <= 1'b0;
      s1_romsel   <= 1'b0;
      cfg_busy    <= 1'b0;
      out_valid   <= 1'b0;
      ROM_ADDR    <= '0;
      ROM_HIT     <= 1'b0;
      IS_SAVERAM  <= 1'b0;
      IS_ROM      <= 1'b0;
      IS_WRITABLE <= 1'b0;
      region_idx  <= '0;
    end else begin
      s1_valid  <= addr_valid;
      cfg_busy  <= cfg_commit;
      out_valid <= s1_valid;
      if (addr_valid) begin
        s1_romsel <= SNES_ROMSEL;
      end
      // Miss leaves the winner fields at zero; only IS_ROM still follows ROMSEL.
      if (s1_valid) begin
        ROM_ADDR    <= win_base + win_off;
        ROM_HIT     <= any_hit;
        IS_SAVERAM  <= win_sav;
        IS_ROM      <= ~s1_romsel;
        IS_WRITABLE <= win_wr;
        region_idx  <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_address_map.sv
// Directed bench for address_map: reset defaults, translation modes, priority,
// shadow/commit timing, pipelining and mid-stream reset.
module tb_address_map;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfg_we;
  logic [6:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic        addr_valid;
  logic [23:0] SNES_ADDR;
  logic        SNES_ROMSEL;
  logic        out_valid;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_SAVERAM;
  logic        IS_ROM;
  logic        IS_WRITABLE;
  logic [2:0]  region_idx;

  int checks = 0;
  int errors = 0;

  address_map #(.NUM_REGIONS(4), .RESET_SAVERAM_MASK(24'h00FFFF)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_busy    (cfg_busy),
    .addr_valid  (addr_valid),
    .SNES_ADDR   (SNES_ADDR),
    .SNES_ROMSEL (SNES_ROMSEL),
    .out_valid   (out_valid),
    .ROM_ADDR    (ROM_ADDR),
    .ROM_HIT     (ROM_HIT),
    .IS_SAVERAM  (IS_SAVERAM),
    .IS_ROM      (IS_ROM),
    .IS_WRITABLE (IS_WRITABLE),
    .region_idx  (region_idx)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // exp_st = {out_valid, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}
  task automatic check_res(input string tag, input logic [23:0] ea, input logic [2:0] ei,
                           input logic [4:0] es);
    check({tag, "_addr"}, ROM_ADDR, ea);
    check({tag, "_idx"}, 24'(region_idx), 24'(ei));
    check({tag, "_st"}, 24'({out_valid, ROM_HIT, IS_ROM, IS_SAVERAM, IS_WRITABLE}), 24'(es));
  endtask

  task automatic drive(input logic [23:0] a, input logic rs);
    SNES_ADDR   = a;
    SNES_ROMSEL = rs;
    addr_valid  = 1'b1;
  endtask

  task automatic lookup(input string tag, input logic [23:0] a, input logic rs,
                        input logic [23:0] ea, input logic [2:0] ei, input logic [4:0] es);
    drive(a, rs);
    tick();
    addr_valid = 1'b0;
    check({tag, "_lat"}, 24'(out_valid), 24'(0));
    tick();
    check_res(tag, ea, ei, es);
  endtask

  task automatic cfg_write(input logic [2:0] r, input logic [3:0] g, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = {r, g};
    cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("busy_hi", 24'(cfg_busy), 24'(1));
    tick();
    check("busy_lo", 24'(cfg_busy), 24'(0));
  endtask

  initial begin
    RST = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    addr_valid = 1'b0; SNES_ADDR = '0; SNES_ROMSEL = 1'b1;
    tick();
    tick();
    check_res("reset", 24'h000000, 3'd0, 5'b00000);
    check("reset_busy", 24'(cfg_busy), 24'(0));
    RST = 1'b0;
    tick();

    // Default map translations
    lookup("r0_lorom",   24'h008123, 1'b0, 24'h000123, 3'd0, 5'b11100);
    lookup("r3_sram",    24'h706ABC, 1'b0, 24'hE06ABC, 3'd3, 5'b11111);
    lookup("r1_linear",  24'h458000, 1'b0, 24'h458000, 3'd1, 5'b11100);
    lookup("r0_mirror",  24'h808123, 1'b0, 24'h000123, 3'd0, 5'b11100);
    lookup("r0_romsel",  24'h008123, 1'b1, 24'h000000, 3'd0, 5'b10000);
    lookup("r2_sram_hi", 24'h007FFF, 1'b1, 24'hE01FFF, 3'd2, 5'b11011);

    // Back-to-back lookups, one result per cycle, then hold
    drive(24'h7E1234, 1'b1);
    tick();
    drive(24'h3F8000, 1'b0);
    tick();
    check_res("b2b_miss", 24'h000000, 3'd0, 5'b10000);
    drive(24'h5FFFFF, 1'b0);
    tick();
    check_res("b2b_r0", 24'h1F8000, 3'd0, 5'b11100);
    drive(24'h7D0000, 1'b0);
    tick();
    check_res("b2b_r1", 24'h5FFFFF, 3'd1, 5'b11100);
    addr_valid = 1'b0;
    tick();
    check_res("b2b_r3", 24'hE00000, 3'd3, 5'b11111);
    tick();
    check_res("hold", 24'hE00000, 3'd3, 5'b01111);

    // Shadow writes are invisible until commit; busy-cycle lookup sees new map
    cfg_write(3'd0, 4'd4, 8'h00);
    cfg_write(3'd0, 4'd5, 8'h00);
    cfg_write(3'd0, 4'd6, 8'h10);
    lookup("no_commit", 24'h808000, 1'b0, 24'h000000, 3'd0, 5'b11100);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("busy_cycle", 24'(cfg_busy), 24'(1));
    drive(24'h808000, 1'b0);
    tick();
    addr_valid = 1'b0;
    check("busy_done", 24'(cfg_busy), 24'(0));
    tick();
    check_res("committed", 24'h100000, 3'd0, 5'b11100);

    // Write coincident with commit is left for the following commit
    cfg_we = 1'b1; cfg_addr = {3'd0, 4'd6}; cfg_data = 8'h20; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    tick();
    lookup("coincident", 24'h808000, 1'b0, 24'h100000, 3'd0, 5'b11100);
    commit();
    lookup("next_commit", 24'h808000, 1'b0, 24'h200000, 3'd0, 5'b11100);

    // Commit while lookups are in flight
    cfg_write(3'd0, 4'd6, 8'h30);
    drive(24'h808000, 1'b0);
    tick();
    drive(24'h808000, 1'b0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check_res("inflight_s2", 24'h200000, 3'd0, 5'b11100);
    check("inflight_busy", 24'(cfg_busy), 24'(1));
    drive(24'h808000, 1'b0);
    tick();
    addr_valid = 1'b0;
    check_res("inflight_s1", 24'h200000, 3'd0, 5'b11100);
    tick();
    check_res("after_busy", 24'h300000, 3'd0, 5'b11100);

    // Out-of-range region/register writes are dropped
    cfg_write(3'd4, 4'd0, 8'hFF);
    cfg_write(3'd0, 4'd11, 8'h00);
    cfg_write(3'd0, 4'd15, 8'h00);
    commit();
    lookup("ignored_wr", 24'h808000, 1'b0, 24'h300000, 3'd0, 5'b11100);

    // R3 moved over R2's window: lower index wins
    cfg_write(3'd3, 4'd0, 8'h00);
    cfg_write(3'd3, 4'd1, 8'h3F);
    cfg_write(3'd3, 4'd2, 8'h60);
    cfg_write(3'd3, 4'd3, 8'h7F);
    commit();
    lookup("overlap", 24'h006000, 1'b0, 24'hE00000, 3'd2, 5'b11111);
    lookup("r3_moved", 24'h706ABC, 1'b0, 24'h000000, 3'd0, 5'b10100);

    // Disabling R2 lets R3 take the window
    cfg_write(3'd2, 4'd10, 8'h00);
    commit();
    lookup("r2_off", 24'h006000, 1'b0, 24'hE06000, 3'd3, 5'b11111);

    // Reset with a lookup in stage 1
    drive(24'h808000, 1'b0);
    tick();
    RST = 1'b1;
    #2;
    addr_valid = 1'b0;
    check_res("rst_mid", 24'h000000, 3'd0, 5'b00000);
    tick();
    RST = 1'b0;
    tick();
    check("rst_discard", 24'(out_valid), 24'(0));
    lookup("rst_r0", 24'h808123, 1'b0, 24'h000123, 3'd0, 5'b11100);
    lookup("rst_r3", 24'h706ABC, 1'b0, 24'hE06ABC, 3'd3, 5'b11111);
    lookup("rst_r2", 24'h006000, 1'b1, 24'hE00000, 3'd2, 5'b11011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
